// File: rtl/fm_pkg.sv
// Shared definitions for the FSK keyer: state encoding, frame geometry and
// default word widths.
package fm_pkg;

  localparam int HZ_SZ      = 32;
  localparam int CNT_SZ     = 24;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int IDX_SZ     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    FSK_IDLE  = 2'd0,
    FSK_START = 2'd1,
    FSK_DATA  = 2'd2,
    FSK_STOP  = 2'd3
  } fsk_state_t;

endpackage

// File: rtl/fsk_bit_timer.sv
// Loadable bit-period down-counter. A load of N starts a period of
// max(N,1) cycles; bit_end is high in the last cycle of the period.
module fsk_bit_timer #(
  parameter int p_cnt_sz = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [p_cnt_sz-1:0] cycles,
  output logic                bit_end
);

  logic [p_cnt_sz-1:0] cnt;

  // Count down to zero and hold; a load restarts the period at N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (cycles == '0) ? '0 : cycles - p_cnt_sz'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - p_cnt_sz'(1);
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/fsk_seq.sv
// Byte-framed FSK keyer: start bit, 8 data bits LSB first, stop bit, each
// held for a programmable number of cycles on the mark/space shift word.
//
// Handshake: a byte is taken in any cycle where i_valid && o_ready; i_data
// must stay stable while i_valid is high and o_ready is low. o_ready is high
// in IDLE and in the last cycle of STOP, so back-to-back frames have no gap.
module fsk_seq
  import fm_pkg::*;
#(
  parameter int p_hz_sz  = HZ_SZ,
  parameter int p_cnt_sz = CNT_SZ
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [p_cnt_sz-1:0] i_bit_cycles,
  input  logic [p_hz_sz-1:0]  i_mark_hz,
  input  logic [p_hz_sz-1:0]  i_space_hz,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [p_hz_sz-1:0]  o_shift_hz,
  output logic                o_key,
  output logic                o_busy,
  output fsk_state_t          o_state
);

  fsk_state_t          state;
  fsk_state_t          state_next;
  logic                bit_end;
  logic                hs;
  logic                timer_load;
  logic [p_cnt_sz-1:0] timer_cycles;

  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [IDX_SZ-1:0]    idx, idx_next;
  logic [p_hz_sz-1:0]   mark_q, mark_next;
  logic [p_hz_sz-1:0]   space_q, space_next;
  logic [p_cnt_sz-1:0]  cycles_q, cycles_next;
  logic                 key_next;
  logic [p_hz_sz-1:0]   hz_next;

  assign hs           = i_valid && o_ready;
  // Bit timing restarts on a new frame and at every bit end inside a frame.
  assign timer_load   = hs || ((state != FSK_IDLE) && bit_end);
  assign timer_cycles = hs ? i_bit_cycles : cycles_q;
  assign o_state      = state;

  fsk_bit_timer #(.p_cnt_sz(p_cnt_sz)) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (timer_load),
    .cycles  (timer_cycles),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FSK_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: frame sequencing driven by bit ends and handshakes.
  always_comb begin
    state_next = state;
    case (state)
      FSK_IDLE:  if (hs) state_next = FSK_START;
      FSK_START: if (bit_end) state_next = FSK_DATA;
      FSK_DATA:  if (bit_end && (idx == IDX_SZ'(DATA_BITS - 1))) state_next = FSK_STOP;
      FSK_STOP: begin
        if (hs)           state_next = FSK_START;
        else if (bit_end) state_next = FSK_IDLE;
      end
      default:   state_next = FSK_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    o_ready = (state == FSK_IDLE) || ((state == FSK_STOP) && bit_end);
    o_busy  = (state != FSK_IDLE);
  end

  // Datapath next values: latch the frame at a handshake, shift at data bit
  // ends, and pick the line bit the next state will present.
  always_comb begin
    shift_next  = shift_reg;
    idx_next    = idx;
    mark_next   = mark_q;
    space_next  = space_q;
    cycles_next = cycles_q;
    if (hs) begin
      shift_next  = i_data;
      idx_next    = '0;
      mark_next   = i_mark_hz;
      space_next  = i_space_hz;
      cycles_next = i_bit_cycles;
    end else if ((state == FSK_DATA) && bit_end) begin
      shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
      idx_next   = idx + IDX_SZ'(1);
    end
    case (state_next)
      FSK_START: key_next = 1'b0;
      FSK_DATA:  key_next = shift_next[0];
      default:   key_next = 1'b1;
    endcase
    // Idle tracks the live mark word; inside a frame only latched words are used.
    if (state_next == FSK_IDLE) hz_next = i_mark_hz;
    else                        hz_next = key_next ? mark_next : space_next;
  end

  // Datapath registers, including the registered key/shift outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_reg  <= '0;
      idx        <= '0;
      mark_q     <= '0;
      space_q    <= '0;
      cycles_q   <= '0;
      o_key      <= 1'b1;
      o_shift_hz <= '0;
    end else begin
      shift_reg  <= shift_next;
      idx        <= idx_next;
      mark_q     <= mark_next;
      space_q    <= space_next;
      cycles_q   <= cycles_next;
      o_key      <= key_next;
      o_shift_hz <= hz_next;
    end
  end

endmodule

// File: tb/tb_fsk_seq.sv
// Self-checking bench for fsk_seq: frame table, directed corner sequences and
// randomized traffic against a per-cycle expected-output queue.
module tb_fsk_seq;
  import fm_pkg::*;

  localparam int HZ  = 32;
  localparam int CNT = 24;

  // Clock and DUT signals.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [CNT-1:0] bit_cycles;
  logic [HZ-1:0]  mark_hz, space_hz;
  logic [7:0]     data;
  logic           valid;
  logic           ready, key, busy;
  logic [HZ-1:0]  shift_hz;
  fsk_state_t     dbg_state;

  fsk_seq #(.p_hz_sz(HZ), .p_cnt_sz(CNT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bit_cycles (bit_cycles),
    .i_mark_hz    (mark_hz),
    .i_space_hz   (space_hz),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_shift_hz   (shift_hz),
    .o_key        (key),
    .o_busy       (busy),
    .o_state      (dbg_state)
  );

  // Reference model: one queued entry per expected busy cycle.
  typedef struct packed {
    logic          key;
    logic          busy;
    logic [HZ-1:0] hz;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [HZ-1:0] idle_hz  = '0;
  bit            model_on = 1'b0;
  bit            last_hs  = 1'b0;

  typedef struct {
    logic [7:0]     d;
    logic [CNT-1:0] n;
    logic [HZ-1:0]  m;
    logic [HZ-1:0]  s;
    logic [9:0]     bits;
    int             len;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame = start(0), data LSB first, stop(1); each bit max(n,1) cycles.
  task automatic push_frame(input logic [7:0] d, input logic [CNT-1:0] n,
                            input logic [HZ-1:0] m, input logic [HZ-1:0] s);
    int per;
    per = (n == '0) ? 1 : int'(n);
    for (int b = 0; b < 10; b++) begin
      logic lb;
      exp_t e;
      if (b == 0)      lb = 1'b0;
      else if (b == 9) lb = 1'b1;
      else             lb = d[b-1];
      e.key  = lb;
      e.busy = 1'b1;
      e.hz   = lb ? m : s;
      for (int c = 0; c < per; c++) exp_q.push_back(e);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance one clock.
  task automatic step();
    exp_t e;
    logic exp_ready;
    last_hs   = 1'b0;
    exp_ready = 1'b1;
    if (model_on) begin
      exp_ready = (exp_q.size() <= 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.key  = 1'b1;
        e.busy = 1'b0;
        e.hz   = idle_hz;
      end
      check("model_out", {ready, busy, key, shift_hz}, {exp_ready, e.busy, e.key, e.hz});
    end
    if (rst) begin
      exp_q.delete();
      idle_hz  = '0;
      model_on = 1'b1;
    end else begin
      if (valid && exp_ready) begin
        last_hs = 1'b1;
        push_frame(data, bit_cycles, mark_hz, space_hz);
      end
      idle_hz = mark_hz;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int per, busy_cnt, hs_cnt;
    logic exp_key;

    vecs[0] = '{d: 8'hA5, n: 24'd4, m: 32'd1200, s: 32'd2200, bits: 10'b1101001010, len: 40};
    vecs[1] = '{d: 8'h00, n: 24'd0, m: 32'd1200, s: 32'd2200, bits: 10'b1000000000, len: 10};
    vecs[2] = '{d: 8'hFF, n: 24'd2, m: 32'd1500, s: 32'd2500, bits: 10'b1111111110, len: 20};
    vecs[3] = '{d: 8'h0F, n: 24'd1, m: 32'd900,  s: 32'd1800, bits: 10'b1000011110, len: 10};

    rst = 1'b1; valid = 1'b0; data = '0; bit_cycles = 24'd4;
    mark_hz = 32'd1200; space_hz = 32'd2200;
    @(posedge clk); #1;
    step();
    rst = 1'b0;

    // Reset state, then idle follows the live mark word.
    check("t1_after_rst", {ready, key, busy, shift_hz}, {1'b1, 1'b1, 1'b0, 32'd0});
    step();
    check("t1_idle", {ready, key, busy, shift_hz}, {1'b1, 1'b1, 1'b0, 32'd1200});
    step();

    // Frame table from idle.
    for (int v = 0; v < 4; v++) begin
      data = vecs[v].d; bit_cycles = vecs[v].n;
      mark_hz = vecs[v].m; space_hz = vecs[v].s;
      valid = 1'b1;
      step();
      valid = 1'b0;
      per = vecs[v].len / 10;
      for (int c = 0; c < vecs[v].len; c++) begin
        exp_key = vecs[v].bits[c / per];
        check("tbl_key", key, exp_key);
        check("tbl_busy", busy, 1'b1);
        check("tbl_hz", shift_hz, exp_key ? vecs[v].m : vecs[v].s);
        step();
      end
      check("tbl_end", busy, 1'b0);
      step();
    end

    // Back-to-back frames with i_valid held high.
    mark_hz = 32'd1200; space_hz = 32'd2200; bit_cycles = 24'd3;
    data = 8'h55; valid = 1'b1;
    step();
    data = 8'h0F; hs_cnt = 1; busy_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (busy) busy_cnt++;
      step();
      if (last_hs) begin
        hs_cnt++;
        valid = 1'b0;
      end
    end
    check("t4_busy_cycles", busy_cnt, 60);
    check("t4_handshakes", hs_cnt, 2);

    // Mid-frame configuration change only affects the next frame.
    bit_cycles = 24'd2; data = 8'h00; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    space_hz = 32'd3000;
    step();
    check("t5_keep_space", shift_hz, 32'd2200);
    for (int i = 0; i < 30; i++) step();
    valid = 1'b1;
    step();
    valid = 1'b0;
    check("t5_new_space", {key, shift_hz}, {1'b0, 32'd3000});
    for (int i = 0; i < 25; i++) step();

    // Reset in the middle of data bit 3.
    bit_cycles = 24'd2; data = 8'hFF; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t6_in_data", dbg_state, FSK_DATA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_state", {ready, key, busy, shift_hz}, {1'b1, 1'b1, 1'b0, 32'd0});
    bit_cycles = 24'd1; data = 8'h3C; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 15; i++) step();

    // Randomized traffic; a pending byte is held until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(valid && !last_hs)) begin
        valid = ($urandom_range(0, 1) == 1);
        data  = 8'($urandom_range(0, 255));
      end
      bit_cycles = CNT'($urandom_range(0, 4));
      mark_hz    = HZ'($urandom_range(1000, 1500));
      space_hz   = HZ'($urandom_range(2000, 2500));
      step();
    end
    rst = 1'b0; valid = 1'b0;
    for (int i = 0; i < 60; i++) step();
    check("drain_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
